// File: rtl/rast_sample_iterator.sv
// rast_sample_iterator: walks every subsample of a captured bounding box in raster order,
// one candidate per cycle, holding the upstream pipeline until the walk is about to finish.
module rast_sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    input  logic signed [SIGFIG-1:0] box_R13S [2][2],
    input  logic                     validTri_R13H,
    input  logic [3:0]               subSample_RnnnnU,
    input  logic                     halt_R14L,
    output logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    output logic signed [SIGFIG-1:0] sample_R14S [2],
    output logic                     validSamp_R14H
);
    typedef enum logic {WAIT, TEST} state_t;
    state_t state, state_nx;
    // one guard bit so x + step next to the screen edge cannot wrap
    logic signed [SIGFIG:0] step, ll_x, ur_x, ur_y, sx, sy;
    logic signed [SIGFIG:0] in_step, in_llx, in_lly, in_urx, in_ury, wx, nx, ny;
    logic [1:0] ss_lg2;
    logic wrap, last_in, last_nx, cap;

    assign ss_lg2  = subSample_RnnnnU[3] ? 2'd0 : subSample_RnnnnU[2] ? 2'd1 :
                     subSample_RnnnnU[1] ? 2'd2 : 2'd3;
    assign in_step = (SIGFIG+1)'(1) << (RADIX - int'(ss_lg2));
    assign in_llx  = (SIGFIG+1)'(box_R13S[0][0]);
    assign in_lly  = (SIGFIG+1)'(box_R13S[0][1]);
    assign in_urx  = (SIGFIG+1)'(box_R13S[1][0]);
    assign in_ury  = (SIGFIG+1)'(box_R13S[1][1]);

    assign wx      = sx + step;
    assign wrap    = wx > ur_x;
    assign nx      = wrap ? ll_x : wx;
    assign ny      = wrap ? sy + step : sy;
    assign last_nx = (nx + step > ur_x) && (ny + step > ur_y);
    assign last_in = (in_llx + in_step > in_urx) && (in_lly + in_step > in_ury);

    // release upstream on the edge that emits the final sample so boxes stream back to back
    assign halt_RnnnnL = halt_R14L && (state == WAIT || last_nx);
    assign sample_R14S = '{sx[SIGFIG-1:0], sy[SIGFIG-1:0]};

    always_comb begin
        state_nx = state;
        cap      = halt_R14L && state == WAIT && validTri_R13H;
        if (cap && !last_in)
            state_nx = TEST;
        else if (halt_R14L && state == TEST && last_nx)
            state_nx = WAIT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= WAIT;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step           <= '0;
            ll_x           <= '0;
            ur_x           <= '0;
            ur_y           <= '0;
            sx             <= '0;
            sy             <= '0;
            validSamp_R14H <= 1'b0;
            tri_R14S       <= '{default: '0};
        end else if (halt_R14L) begin
            if (state == TEST) begin
                sx             <= nx;
                sy             <= ny;
                validSamp_R14H <= 1'b1;
            end else begin
                validSamp_R14H <= validTri_R13H;
                if (cap) begin
                    step     <= in_step;
                    ll_x     <= in_llx;
                    ur_x     <= in_urx;
                    ur_y     <= in_ury;
                    sx       <= in_llx;
                    sy       <= in_lly;
                    tri_R14S <= tri_R13S;
                end
            end
        end
    end
endmodule

// File: tb/tb_rast_sample_iterator.sv
// tb_rast_sample_iterator: random and directed boxes checked against a raster-walk scoreboard.
module tb_rast_sample_iterator;
    logic clk, rst, validTri_R13H, halt_R14L, halt_RnnnnL, validSamp_R14H;
    logic [3:0] subSample_RnnnnU;
    logic signed [23:0] tri_i [3][3];
    logic signed [23:0] tri_o [3][3];
    logic signed [23:0] box [2][2];
    logic signed [23:0] samp [2];

    typedef struct {int x; int y; bit hl; int t0; int t8;} exp_t;
    exp_t q[$];
    int tests = 0, fails = 0, rem = 0;
    int p_llx, p_lly, p_urx, p_ury, p_lg2, p_t0;
    bit captured = 0, stall_en = 0;

    rast_sample_iterator dut (
        .clk(clk), .rst(rst), .tri_R13S(tri_i), .box_R13S(box),
        .validTri_R13H(validTri_R13H), .subSample_RnnnnU(subSample_RnnnnU),
        .halt_R14L(halt_R14L), .halt_RnnnnL(halt_RnnnnL), .tri_R14S(tri_o),
        .sample_R14S(samp), .validSamp_R14H(validSamp_R14H)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(string name, int got, int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // expected stream of one box: every grid point x<=ur_x, y<=ur_y in raster order
    task automatic push_box();
        int st = 1 << (10 - p_lg2);
        int w = (p_urx - p_llx) / st + 1;
        int h = (p_ury - p_lly) / st + 1;
        int n = w * h, k = 0;
        exp_t e;
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++) begin
                k++;
                e.x = p_llx + i * st;
                e.y = p_lly + j * st;
                e.hl = (k >= n - 1);
                e.t0 = p_t0;
                e.t8 = p_t0 + 8;
                q.push_back(e);
            end
        rem = n - 1;
    endtask

    // one clock of the upstream model: a box is taken only when the previous walk has finished
    task automatic cycle();
        bit cap = 0;
        @(negedge clk);
        if (rst && halt_R14L) begin
            if (rem > 0) rem--;
            else if (validTri_R13H) cap = 1;
        end
        @(posedge clk);
        #1;
        captured = cap;
        if (cap) push_box();
        if (stall_en) halt_R14L = ($urandom_range(3) != 0);
    endtask

    task automatic send(int llx, int lly, int urx, int ury, int lg2);
        int g = 0;
        p_llx = llx; p_lly = lly; p_urx = urx; p_ury = ury; p_lg2 = lg2;
        p_t0 = int'($urandom_range(22'h3fffff));
        box[0][0] = 24'(llx); box[0][1] = 24'(lly);
        box[1][0] = 24'(urx); box[1][1] = 24'(ury);
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                tri_i[v][a] = 24'(p_t0 + v * 3 + a);
        subSample_RnnnnU = 4'b1000 >> lg2;
        validTri_R13H = 1;
        captured = 0;
        do begin
            cycle();
            g++;
        end while (!captured && g < 500);
        chk("capture", int'(captured), 1);
        subSample_RnnnnU = 4'b1000 >> $urandom_range(3);
    endtask

    task automatic drain();
        int g = 0;
        validTri_R13H = 0;
        while (q.size() > 0 && g < 1000) begin
            cycle();
            g++;
        end
        chk("drain", q.size(), 0);
        cycle();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                tests++;
                if (validSamp_R14H) begin
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL extra sample got (%0d,%0d) want none", int'(samp[0]), int'(samp[1]));
                    end else begin
                        e = q[0];
                        if (int'(samp[0]) != e.x || int'(samp[1]) != e.y || int'(tri_o[0][0]) != e.t0 ||
                            int'(tri_o[2][2]) != e.t8 || halt_RnnnnL != (halt_R14L && e.hl)) begin
                            fails++;
                            $display("FAIL sample got (%0d,%0d) tri %0d/%0d halt %0b want (%0d,%0d) tri %0d/%0d halt %0b",
                                     int'(samp[0]), int'(samp[1]), int'(tri_o[0][0]), int'(tri_o[2][2]),
                                     halt_RnnnnL, e.x, e.y, e.t0, e.t8, halt_R14L && e.hl);
                        end
                        if (halt_R14L) void'(q.pop_front());
                    end
                end else if (halt_RnnnnL != halt_R14L || (halt_R14L && q.size() > 0)) begin
                    fails++;
                    $display("FAIL idle halt %0b want %0b pending %0d want 0", halt_RnnnnL, halt_R14L, q.size());
                end
            end
        end
    end

    initial begin
        rst = 1; halt_R14L = 1; validTri_R13H = 0; subSample_RnnnnU = 4'b1000;
        box = '{default: '0}; tri_i = '{default: '0};
        #2 rst = 0;
        #1;
        chk("reset valid", int'(validSamp_R14H), 0);
        chk("reset x", int'(samp[0]), 0);
        chk("reset y", int'(samp[1]), 0);
        chk("reset tri", int'(tri_o[0][0]), 0);
        chk("reset halt", int'(halt_RnnnnL), 1);
        @(posedge clk);
        #1 rst = 1;

        send(0, 0, 2048, 1024, 0);       drain();
        send(5120, 3072, 5120, 3072, 0); drain();
        send(0, 0, 256, 128, 3);         drain();
        send(0, 0, 1024, 0, 0);
        send(2048, 2048, 2048, 3072, 0); drain();
        send(-4096, 1024, -2048, 1500, 1); drain();
        send(8386560, 0, 8388607, 0, 0); drain();

        send(0, 0, 2048, 1024, 0);
        validTri_R13H = 0;
        cycle();
        halt_R14L = 0;
        repeat (3) cycle();
        halt_R14L = 1;
        drain();

        send(0, 0, 2048, 1024, 0);
        validTri_R13H = 0;
        cycle();
        cycle();
        rst = 0;
        #1;
        chk("midreset valid", int'(validSamp_R14H), 0);
        chk("midreset x", int'(samp[0]), 0);
        chk("midreset halt", int'(halt_RnnnnL), 1);
        q.delete();
        rem = 0;
        cycle();
        rst = 1;
        send(1024, 2048, 2048, 2048, 0); drain();

        stall_en = 1;
        for (int n = 0; n < 40; n++) begin
            int lg2 = int'($urandom_range(3));
            int st = 1 << (10 - lg2);
            int llx = st * (int'($urandom_range(40)) - 20);
            int lly = st * (int'($urandom_range(40)) - 20);
            int urx = llx + st * int'($urandom_range(3)) + int'($urandom_range(st - 1));
            int ury = lly + st * int'($urandom_range(2)) + int'($urandom_range(st - 1));
            send(llx, lly, urx, ury, lg2);
            if ($urandom_range(1) == 1) begin
                validTri_R13H = 0;
                repeat ($urandom_range(3)) cycle();
            end
        end
        stall_en = 0;
        halt_R14L = 1;
        drain();
        chk("final rem", rem, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
